// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters
module onchip_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  logic req0, req1, gnt0, gnt1;
  logic last_q, last_d, rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d, clken_q;
  // Grants are held off until the RAM clock enable is up, one cycle after reset release
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = clken_q & req0 & (~req1 | last_q);
    gnt1 = clken_q & req1 & (~req0 | ~last_q);
    last_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
    rd_pend_d = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
    rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
    m0_waitrequest = ~gnt0;
    m1_waitrequest = ~gnt1;
    mem_chipselect = gnt0 | gnt1;
    mem_write = gnt0 ? m0_write : gnt1 ? m1_write : 1'b0;
    mem_address = gnt0 ? m0_address : gnt1 ? m1_address : '0;
    mem_byteenable = gnt0 ? m0_byteenable : gnt1 ? m1_byteenable : '0;
    mem_writedata = gnt0 ? m0_writedata : gnt1 ? m1_writedata : '0;
    m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = rd_pend_q & rd_owner_q;
    m0_readdata = mem_readdata;
    m1_readdata = mem_readdata;
    mem_clken = clken_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_owner_q <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      last_q <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      clken_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed stimulus with per-master read-data scoreboards and a RAM model
module tb_onchip_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] rd = '0, wr = '0;
  logic [15:0] addr [2];
  logic [3:0] ben [2];
  logic [31:0] wd [2];
  wire [1:0] wreq, rdv;
  wire [31:0] rdat0, rdat1;
  wire [15:0] mem_address;
  wire [3:0] mem_byteenable;
  wire mem_chipselect, mem_write, mem_clken;
  wire [31:0] mem_writedata;
  logic [31:0] ram [65536];
  logic [31:0] ram_q = '0;
  logic [31:0] q0 [$], q1 [$];
  int glog [$], gcyc [$];
  int checks = 0, errors = 0, cyc = 0;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(addr[0]), .m0_byteenable(ben[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wd[0]), .m0_waitrequest(wreq[0]), .m0_readdata(rdat0), .m0_readdatavalid(rdv[0]),
    .m1_address(addr[1]), .m1_byteenable(ben[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wd[1]), .m1_waitrequest(wreq[1]), .m1_readdata(rdat1), .m1_readdatavalid(rdv[1]),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with registered address: q shows the word addressed at the previous edge
  always @(posedge clk)
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else ram_q <= ram[mem_address];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data whenever a readdatavalid appears, logs grants
  always @(negedge clk) begin
    if (rdv[0]) begin
      if (q0.size() == 0) chk("m0 unexpected rdv", 32'd1, 32'd0);
      else chk("m0 readdata", rdat0, q0.pop_front());
    end
    if (rdv[1]) begin
      if (q1.size() == 0) chk("m1 unexpected rdv", 32'd1, 32'd0);
      else chk("m1 readdata", rdat1, q1.pop_front());
    end
    if (reset_n) begin
      chk("chipselect vs grant", {31'd0, mem_chipselect}, {31'd0, ~&wreq});
      if (wreq == 2'b00) chk("double grant", {30'd0, wreq}, 32'd3);
    end
    if (!wreq[0]) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (!wreq[1]) begin glog.push_back(1); gcyc.push_back(cyc); end
  end

  // Issue one transfer on master m, starting just after a rising edge; returns just after acceptance edge
  task automatic op(input int m, input bit r, input bit w, input logic [15:0] a,
                    input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp);
    int n = 0;
    rd[m] = r; wr[m] = w; addr[m] = a; ben[m] = be; wd[m] = d;
    forever begin
      @(negedge clk);
      if (!wreq[m]) break;
      if (++n > 20) begin
        chk("accept timeout", {31'd0, wreq[m]}, 32'd0);
        break;
      end
    end
    if (!wreq[m] && r && !w) begin
      if (m == 0) q0.push_back(exp); else q1.push_back(exp);
    end
    @(posedge clk); #1;
    rd[m] = 1'b0; wr[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; ben[i] = '0; wd[i] = '0; end
    // Reset with both masters requesting writes
    wr = 2'b11; addr[0] = 16'h0040; wd[0] = 32'h1; ben[0] = 4'hF;
    addr[1] = 16'h0041; wd[1] = 32'h2; ben[1] = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset waitreq", {30'd0, wreq}, 32'd3);
    chk("reset chipselect", {31'd0, mem_chipselect}, 32'd0);
    chk("reset mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset rdv", {30'd0, rdv}, 32'd0);
    chk("reset clken", {31'd0, mem_clken}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post-release waitreq", {30'd0, wreq}, 32'd3);
    chk("post-release clken", {31'd0, mem_clken}, 32'd0);
    @(negedge clk);
    chk("first grant m0", {30'd0, wreq}, 32'd2);
    chk("first grant addr", {16'd0, mem_address}, 32'h40);
    chk("first grant write", {31'd0, mem_write}, 32'd1);
    chk("clken up", {31'd0, mem_clken}, 32'd1);
    @(posedge clk); #1 wr[0] = 1'b0;
    @(negedge clk);
    chk("second grant m1", {30'd0, wreq}, 32'd1);
    @(posedge clk); #1 wr[1] = 1'b0;
    // Single master write/read and byte lanes
    op(0, 0, 1, 16'h0010, 4'hF, 32'hDEADBEEF, 0);
    op(0, 1, 0, 16'h0010, 4'hF, 0, 32'hDEADBEEF);
    op(0, 0, 1, 16'h0020, 4'hF, 32'h11223344, 0);
    op(0, 0, 1, 16'h0020, 4'h8, 32'hAA000000, 0);
    op(0, 1, 0, 16'h0020, 4'hF, 0, 32'hAA223344);
    op(0, 1, 0, 16'h0041, 4'hF, 0, 32'h2);
    // Read+write together is a write
    op(1, 1, 1, 16'h0030, 4'hF, 32'h5A5A5A5A, 0);
    op(1, 1, 0, 16'h0030, 4'hF, 0, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) op(0, 0, 1, 16'h0100 + 16'(i), 4'hF, 32'hA0000000 + i, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 1, 16'h0200 + 16'(i), 4'hF, 32'hB0000000 + i, 0);
    // Contention: both masters stream four reads each
    glog.delete(); gcyc.delete();
    fork
      for (int i = 0; i < 4; i++) op(0, 1, 0, 16'h0100 + 16'(i), 4'hF, 0, 32'hA0000000 + i);
      for (int i = 0; i < 4; i++) op(1, 1, 0, 16'h0200 + 16'(i), 4'hF, 0, 32'hB0000000 + i);
    join
    chk("contention grants", glog.size(), 8);
    if (glog.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("grant order", glog[i], i % 2);
      chk("grant span", gcyc[7] - gcyc[0], 7);
    end
    repeat (3) @(posedge clk); #1;
    // Reset in the cycle after an accepted read
    rd[0] = 1'b1; addr[0] = 16'h0010; n = 0;
    forever begin
      @(negedge clk);
      if (!wreq[0]) break;
      if (++n > 20) begin chk("mid-read accept timeout", 32'd1, 32'd0); break; end
    end
    @(posedge clk); #1 rd[0] = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk("mid-read rdv", {30'd0, rdv}, 32'd0);
    chk("mid-read rd_pend", {31'd0, dut.rd_pend_q}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    op(0, 1, 0, 16'h0010, 4'hF, 0, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("m0 queue drained", q0.size(), 0);
    chk("m1 queue drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master arbiter that shares the single-port 64 Ki x 32 on-chip RAM between the Nios II data master (port m0) and a secondary streaming master such as a DMA or video reader (port m1). It presents two Avalon-MM slave interfaces with `waitrequest`/`readdatavalid` and drives the RAM's `address`/`byteenable`/`chipselect`/`write`/`writedata`/`clken` pins directly. It sits between the system interconnect and the RAM instance and provides round-robin fairness at one transfer per clock.

## Interface
- `ADDR_W`, 16, word address width (matches the 65536-word RAM)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (`DATA_W/8`)

- `clk`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `m0_address`  in  ADDR_W  master 0 word address
- `m0_byteenable`  in  BE_W  master 0 byte lanes
- `m0_read`  in  1  master 0 read request
- `m0_write`  in  1  master 0 write request
- `m0_writedata`  in  DATA_W  master 0 write data
- `m0_waitrequest`  out  1  low = master 0 transfer accepted this cycle
- `m0_readdata`  out  DATA_W  read data to master 0
- `m0_readdatavalid`  out  1  `m0_readdata` valid this cycle
- `m1_*`  same set and meaning as `m0_*`, for master 1
- `mem_address`  out  ADDR_W  to RAM `address`
- `mem_byteenable`  out  BE_W  to RAM `byteenable`
- `mem_chipselect`  out  1  to RAM `chipselect`
- `mem_write`  out  1  to RAM `write`
- `mem_writedata`  out  DATA_W  to RAM `writedata`
- `mem_clken`  out  1  to RAM `clken`
- `mem_readdata`  in  DATA_W  from RAM `readdata` (unregistered q, valid the cycle after address is clocked)

## Operation
- Request: `reqX = mX_read | mX_write`. Masters hold all request signals stable until `mX_waitrequest` is low (Avalon rule).
- Arbitration is evaluated combinationally every cycle from `req0`, `req1` and register `last_grant`:
  - only one request: grant it;
  - both: grant the master not equal to `last_grant`;
  - none: no grant.
- On grant of X: `mX_waitrequest` = 0 in that cycle, `mem_chipselect` = 1, and `mem_address`/`mem_byteenable`/`mem_writedata` come from X. `mem_write` = `mX_write`. At the clock edge `last_grant` <= X.
- Ungranted master: `mX_waitrequest` = 1, including when it is idle.
- No grant: `mem_chipselect` = 0, `mem_write` = 0, and `mem_address`/`mem_byteenable`/`mem_writedata` = 0.
- Both `mX_read` and `mX_write` high: treated as a write. No `readdatavalid` is produced.
- Read return: on an accepted read, register `rd_pend` <= 1 and `rd_owner` <= X. Next cycle, `mX_readdatavalid` = `rd_pend & (rd_owner==X)`. Both `mX_readdata` are driven with `mem_readdata`.
- Write then read of the same address in consecutive cycles returns the new data, because the RAM serializes accesses.
- `mem_clken` is a register: 0 in reset, 1 from the first edge after reset deasserts.

## Timing
- Reset values: `last_grant`=1 (so m0 wins the first tie), `rd_pend`=0, `rd_owner`=0, `mem_clken`=0. While `reset_n`=0: both waitrequests = 1, both readdatavalids = 0, `mem_chipselect`=0, `mem_write`=0.
- Accept latency is 0 cycles when the master is granted in the cycle of request. Read latency is exactly 1 cycle after acceptance (fixed, not variable).
- Throughput is one transfer per cycle total. A lone master is granted every cycle, and its pipelined reads return back-to-back. With both saturating, grants alternate m0, m1, m0, ...
- Maximum wait for any requester is 1 cycle.
- Paths `mX_read`/`mX_write` -> `mY_waitrequest` and -> `mem_*` are combinational. `readdatavalid` is registered through `rd_pend`.
- Reset asserted mid-read: `rd_pend` clears immediately. The pending `readdatavalid` never appears, and the master reissues the read.
- First cycle after reset release: `mem_clken`=0, so no grant is issued (waitrequests stay 1). Grants begin the following cycle.

## Test plan
- Reset: hold `reset_n`=0 with both masters requesting -> waitrequests 1, `mem_chipselect` 0, `readdatavalid` 0. Release reset -> first grant goes to m0 two edges later.
- Single-master write then read: m0 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 -> `m0_readdatavalid` one cycle after accept with 0xDEADBEEF. m1 `readdatavalid` stays 0.
- Byte lanes: write 0x11223344 to 0x0020, then write 0xAA000000 with byteenable 0x8, then read -> 0xAA223344.
- Contention: both masters issue 4 back-to-back reads each (m0 at 0x100-0x103, m1 at 0x200-0x203) -> grants alternate m0,m1,... over 8 cycles. Each master receives its 4 data words in order, each tagged only on its own `readdatavalid`.
- Read+write asserted together on m1 (data 0x5A5A5A5A to 0x0030) -> treated as a write, no `m1_readdatavalid`. A subsequent read returns 0x5A5A5A5A.
- Reset during an accepted read: drop `reset_n` in the cycle after acceptance -> no `readdatavalid` pulse. `rd_pend`=0 after reset.
